// File: rtl/jedro_1_lsu_pkg.sv
// Shared constants and helpers for the jedro_1 load-store unit: widths,
// LSU_CTRL field positions, named ops and store-side lane formatting.
package jedro_1_lsu_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned LSU_CTRL_WIDTH = 4;

  localparam int unsigned LSU_CTRL_STORE_BIT    = 3;
  localparam int unsigned LSU_CTRL_UNSIGNED_BIT = 2;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LB  = 4'b0000;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LH  = 4'b0001;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LW  = 4'b0010;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LBU = 4'b0100;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LHU = 4'b0101;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SB  = 4'b1000;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SH  = 4'b1001;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SW  = 4'b1010;

  // Size 11, unsigned word and unsigned store have no meaning for the core.
  function automatic logic lsu_illegal(input logic [LSU_CTRL_WIDTH-1:0] ctrl);
    return (ctrl[1:0] == 2'b11) ||
           (ctrl[LSU_CTRL_UNSIGNED_BIT] &&
            ((ctrl[1:0] == LSU_SIZE_W) || ctrl[LSU_CTRL_STORE_BIT]));
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == LSU_SIZE_H) && off[0]) ||
           ((size == LSU_SIZE_W) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: return 4'b0001 << off;
      LSU_SIZE_H: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lsu_store_data(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] wdata);
    case (size)
      LSU_SIZE_B: return {4{wdata[7:0]}};
      LSU_SIZE_H: return {2{wdata[15:0]}};
      default:    return wdata;
    endcase
  endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface jedro_1_lsu_if;

  logic                                     data_req_o;
  logic                                     data_gnt_i;
  logic                                     data_we_o;
  logic [3:0]                               data_be_o;
  logic [jedro_1_lsu_pkg::DATA_WIDTH-1:0]   data_addr_o;
  logic [jedro_1_lsu_pkg::DATA_WIDTH-1:0]   data_wdata_o;
  logic                                     data_rvalid_i;
  logic [jedro_1_lsu_pkg::DATA_WIDTH-1:0]   data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );

endinterface

// File: rtl/jedro_1_lsu_load_ext.sv
// Load-data lane select and sign/zero extension driven by the LSU_CTRL size
// and unsigned fields; stores produce no writeback value.
module jedro_1_lsu_load_ext
  import jedro_1_lsu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                addr,
  input  logic [LSU_CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0]     ext
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  uns;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    uns     = ctrl[LSU_CTRL_UNSIGNED_BIT];
    ext     = '0;
    if (!ctrl[LSU_CTRL_STORE_BIT]) begin
      case (ctrl[1:0])
        LSU_SIZE_B: ext = uns ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                              : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        LSU_SIZE_H: ext = uns ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                              : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        default:    ext = shifted;
      endcase
    end
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: blocking, one outstanding access on the data bus,
// load results aligned/extended and handed to writeback with their register.
module jedro_1_lsu
  import jedro_1_lsu_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ctrl_valid_i,
  output logic                      ready_o,
  input  logic [LSU_CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic                      rf_we_o,
  output logic                      misaligned_o,
  jedro_1_lsu_if.master             data_if
);

  // DROP is the one-cycle exit for misaligned and illegal ops so ready_o
  // stays low in the cycle after accept, exactly as for a real access.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e                    state;
  logic [LSU_CTRL_WIDTH-1:0] ctrl_q;
  logic [1:0]                off_q;
  logic [REG_ADDR_WIDTH-1:0] regdest_q;
  logic [DATA_WIDTH-1:0]     load_ext;

  jedro_1_lsu_load_ext u_load_ext (
    .rdata (data_if.data_rdata_i),
    .addr  (off_q),
    .ctrl  (ctrl_q),
    .ext   (load_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                <= IDLE;
      ready_o              <= 1'b1;
      rf_wdata_o           <= '0;
      rf_waddr_o           <= '0;
      rf_we_o              <= 1'b0;
      misaligned_o         <= 1'b0;
      ctrl_q               <= '0;
      off_q                <= '0;
      regdest_q            <= '0;
      data_if.data_req_o   <= 1'b0;
      data_if.data_we_o    <= 1'b0;
      data_if.data_be_o    <= '0;
      data_if.data_addr_o  <= '0;
      data_if.data_wdata_o <= '0;
    end else begin
      rf_we_o      <= 1'b0;
      misaligned_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_valid_i && ready_o) begin
            ready_o   <= 1'b0;
            ctrl_q    <= ctrl_i;
            off_q     <= addr_i[1:0];
            regdest_q <= regdest_i;
            if (lsu_illegal(ctrl_i)) begin
              state <= DROP;
            end else if (lsu_misaligned(ctrl_i[1:0], addr_i[1:0])) begin
              misaligned_o <= 1'b1;
              state        <= DROP;
            end else begin
              state                <= REQ;
              data_if.data_req_o   <= 1'b1;
              data_if.data_we_o    <= ctrl_i[LSU_CTRL_STORE_BIT];
              data_if.data_be_o    <= lsu_be(ctrl_i[1:0], addr_i[1:0]);
              data_if.data_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              data_if.data_wdata_o <= ctrl_i[LSU_CTRL_STORE_BIT] ?
                                      lsu_store_data(ctrl_i[1:0], wdata_i) : '0;
            end
          end
        end
        REQ: begin
          if (data_if.data_gnt_i) begin
            data_if.data_req_o <= 1'b0;
            state              <= WAIT;
          end
        end
        WAIT: begin
          if (data_if.data_rvalid_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            if (!ctrl_q[LSU_CTRL_STORE_BIT]) begin
              rf_we_o    <= 1'b1;
              rf_wdata_o <= load_ext;
              rf_waddr_o <= regdest_q;
            end
          end
        end
        DROP: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_jedro_1_lsu;
  import jedro_1_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_valid = 1'b0;
  logic        ready;
  logic [3:0]  ctrl = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  regdest = '0;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic        misaligned;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  jedro_1_lsu_if data_if ();

  jedro_1_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ctrl_valid_i (ctrl_valid),
    .ready_o      (ready),
    .ctrl_i       (ctrl),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .regdest_i    (regdest),
    .rf_wdata_o   (rf_wdata),
    .rf_waddr_o   (rf_waddr),
    .rf_we_o      (rf_we),
    .misaligned_o (misaligned),
    .data_if      (data_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd);
    ctrl_valid = 1'b1;
    ctrl       = c;
    addr       = a;
    wdata      = w;
    regdest    = rd;
  endtask

  task automatic test_reset();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", ready); end
    vectors++; if (data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%b exp=0", data_if.data_req_o); end
    vectors++; if (data_if.data_we_o !== 1'b0 || data_if.data_be_o !== 4'b0000) begin miscompares++; $display("FAIL rst_we_be got=%b/%b exp=0/0000", data_if.data_we_o, data_if.data_be_o); end
    vectors++; if (data_if.data_addr_o !== 32'h0 || data_if.data_wdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", data_if.data_addr_o, data_if.data_wdata_o); end
    vectors++; if (rf_we !== 1'b0 || misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got=%b/%b exp=0/0", rf_we, misaligned); end
    vectors++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin miscompares++; $display("FAIL rst_rf got=%h/%0d exp=0/0", rf_wdata, rf_waddr); end
  endtask

  task automatic test_load_byte();
    issue(LSU_LB, 32'h0000_0103, 32'h0, 5'd7);
    cyc();  // T+1
    ctrl_valid = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b1) begin miscompares++; $display("FAIL lb_req got=%b exp=1", data_if.data_req_o); end
    vectors++; if (data_if.data_addr_o !== 32'h0000_0100) begin miscompares++; $display("FAIL lb_addr got=%h exp=00000100", data_if.data_addr_o); end
    vectors++; if (data_if.data_be_o !== 4'b1000 || data_if.data_we_o !== 1'b0) begin miscompares++; $display("FAIL lb_be_we got=%b/%b exp=1000/0", data_if.data_be_o, data_if.data_we_o); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL lb_busy got=%b exp=0", ready); end
    data_if.data_gnt_i = 1'b1;
    cyc();  // T+2
    data_if.data_gnt_i   = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL lb_req_drop got=%b exp=0", data_if.data_req_o); end
    data_if.data_rvalid_i = 1'b1;
    data_if.data_rdata_i  = 32'h80AA_BBCC;
    cyc();  // T+3
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (rf_we !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL lb_we_ready got=%b/%b exp=1/1", rf_we, ready); end
    vectors++; if (rf_wdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_wdata got=%h exp=ffffff80", rf_wdata); end
    vectors++; if (rf_waddr !== 5'd7 || misaligned !== 1'b0) begin miscompares++; $display("FAIL lb_waddr got=%0d/%b exp=7/0", rf_waddr, misaligned); end
    data_if.data_gnt_i = 1'b1;  // stray grant while idle
    cyc();  // T+4
    data_if.data_gnt_i = 1'b0;
    vectors++; if (rf_we !== 1'b0 || data_if.data_req_o !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL lb_after got=%b/%b/%b exp=0/0/1", rf_we, data_if.data_req_o, ready); end
  endtask

  task automatic test_store_half();
    issue(LSU_SH, 32'h0000_0202, 32'h1234_ABCD, 5'd9);
    cyc();
    ctrl_valid = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b1 || data_if.data_we_o !== 1'b1) begin miscompares++; $display("FAIL sh_req_we got=%b/%b exp=1/1", data_if.data_req_o, data_if.data_we_o); end
    vectors++; if (data_if.data_addr_o !== 32'h0000_0200) begin miscompares++; $display("FAIL sh_addr got=%h exp=00000200", data_if.data_addr_o); end
    vectors++; if (data_if.data_be_o !== 4'b1100) begin miscompares++; $display("FAIL sh_be got=%b exp=1100", data_if.data_be_o); end
    vectors++; if (data_if.data_wdata_o !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata got=%h exp=abcdabcd", data_if.data_wdata_o); end
    data_if.data_gnt_i = 1'b1;
    cyc();
    data_if.data_gnt_i    = 1'b0;
    data_if.data_rvalid_i = 1'b1;
    cyc();
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (rf_we !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL sh_done got=%b/%b exp=0/1", rf_we, ready); end
  endtask

  task automatic test_store_byte();
    issue(LSU_SB, 32'h0000_0301, 32'h0000_005A, 5'd2);
    cyc();
    ctrl_valid = 1'b0;
    vectors++; if (data_if.data_be_o !== 4'b0010 || data_if.data_wdata_o !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL sb_lane got=%b/%h exp=0010/5a5a5a5a", data_if.data_be_o, data_if.data_wdata_o); end
    data_if.data_gnt_i = 1'b1;
    cyc();
    data_if.data_gnt_i    = 1'b0;
    data_if.data_rvalid_i = 1'b1;
    cyc();
    data_if.data_rvalid_i = 1'b0;
  endtask

  task automatic test_misaligned();
    issue(LSU_LW, 32'h0000_1001, 32'h0, 5'd1);
    cyc();  // T+1
    ctrl_valid = 1'b0;
    vectors++; if (misaligned !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL mis_pulse got=%b/%b exp=1/0", misaligned, data_if.data_req_o); end
    vectors++; if (ready !== 1'b0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL mis_busy got=%b/%b exp=0/0", ready, rf_we); end
    cyc();  // T+2
    vectors++; if (ready !== 1'b1 || misaligned !== 1'b0 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL mis_end got=%b/%b/%b exp=1/0/0", ready, misaligned, data_if.data_req_o); end
    issue(LSU_LH, 32'h0000_0003, 32'h0, 5'd1);
    cyc();
    ctrl_valid = 1'b0;
    vectors++; if (misaligned !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL mis_half got=%b/%b exp=1/0", misaligned, data_if.data_req_o); end
    cyc();
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    ops[0] = 4'b0011;
    ops[1] = 4'b0110;
    ops[2] = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'h0000_0001, 32'hFFFF_FFFF, 5'd5);
      cyc();
      ctrl_valid = 1'b0;
      vectors++; if (data_if.data_req_o !== 1'b0 || misaligned !== 1'b0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL ill_%0d got=%b/%b/%b exp=0/0/0", i, data_if.data_req_o, misaligned, rf_we); end
      cyc();
      vectors++; if (ready !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL ill_end_%0d got=%b/%b exp=1/0", i, ready, data_if.data_req_o); end
    end
  endtask

  task automatic test_delayed_gnt();
    issue(LSU_LHU, 32'h0000_0002, 32'h0, 5'd12);
    cyc();  // T+1
    ctrl_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (data_if.data_req_o !== 1'b1 || data_if.data_addr_o !== 32'h0 || data_if.data_be_o !== 4'b1100) begin miscompares++; $display("FAIL dg_hold_%0d got=%b/%h/%b exp=1/00000000/1100", i, data_if.data_req_o, data_if.data_addr_o, data_if.data_be_o); end
      data_if.data_rvalid_i = (i == 1);  // premature response must be ignored
      data_if.data_rdata_i  = 32'h1111_1111;
      cyc();
    end
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b1 || rf_we !== 1'b0) begin miscompares++; $display("FAIL dg_still got=%b/%b exp=1/0", data_if.data_req_o, rf_we); end
    data_if.data_gnt_i = 1'b1;
    cyc();  // WAIT
    data_if.data_gnt_i = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL dg_wait got=%b/%b exp=0/0", data_if.data_req_o, ready); end
    cyc();
    vectors++; if (rf_we !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL dg_wait2 got=%b/%b exp=0/0", rf_we, ready); end
    cyc();
    data_if.data_rvalid_i = 1'b1;
    data_if.data_rdata_i  = 32'hFEDC_0000;
    cyc();
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_FEDC || rf_waddr !== 5'd12) begin miscompares++; $display("FAIL dg_result got=%b/%h/%0d exp=1/0000fedc/12", rf_we, rf_wdata, rf_waddr); end
  endtask

  task automatic test_reset_mid();
    issue(LSU_LW, 32'h0000_0010, 32'h0, 5'd4);
    cyc();
    ctrl_valid = 1'b0;
    data_if.data_gnt_i = 1'b1;
    cyc();  // WAIT
    data_if.data_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors++; if (ready !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL rw_async got=%b/%b exp=1/0", ready, data_if.data_req_o); end
    cyc();
    rst = 1'b0;
    cyc();
    data_if.data_rvalid_i = 1'b1;
    data_if.data_rdata_i  = 32'hCAFE_F00D;
    cyc();
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (rf_we !== 1'b0 || ready !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL rw_late got=%b/%b/%b exp=0/1/0", rf_we, ready, data_if.data_req_o); end
    issue(LSU_LW, 32'h0000_0020, 32'h0, 5'd4);
    cyc();  // REQ
    ctrl_valid = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b1) begin miscompares++; $display("FAIL rr_req got=%b exp=1", data_if.data_req_o); end
    rst = 1'b1;
    #1;
    vectors++; if (data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL rr_drop got=%b exp=0", data_if.data_req_o); end
    cyc();
    rst = 1'b0;
    cyc();
    vectors++; if (ready !== 1'b1 || data_if.data_req_o !== 1'b0) begin miscompares++; $display("FAIL rr_idle got=%b/%b exp=1/0", ready, data_if.data_req_o); end
  endtask

  task automatic test_back_to_back();
    int unsigned reqs = 0;
    issue(LSU_LW, 32'h0000_0040, 32'h0, 5'd3);
    cyc();  // C1: first op in REQ
    issue(LSU_SW, 32'h0000_0044, 32'hDEAD_BEEF, 5'd0);
    vectors++; if (data_if.data_req_o !== 1'b1 || data_if.data_addr_o !== 32'h40 || data_if.data_we_o !== 1'b0) begin miscompares++; $display("FAIL bb_first got=%b/%h/%b exp=1/00000040/0", data_if.data_req_o, data_if.data_addr_o, data_if.data_we_o); end
    if (data_if.data_req_o === 1'b1) reqs++;
    data_if.data_gnt_i = 1'b1;
    cyc();  // C2: WAIT, SW must not have been taken
    data_if.data_gnt_i = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL bb_hold got=%b/%b exp=0/0", data_if.data_req_o, ready); end
    data_if.data_rvalid_i = 1'b1;
    data_if.data_rdata_i  = 32'h1122_3344;
    cyc();  // C3: writeback, ready, SW accepted at next edge
    data_if.data_rvalid_i = 1'b0;
    vectors++; if (rf_we !== 1'b1 || rf_wdata !== 32'h1122_3344 || rf_waddr !== 5'd3 || ready !== 1'b1) begin miscompares++; $display("FAIL bb_wb got=%b/%h/%0d/%b exp=1/11223344/3/1", rf_we, rf_wdata, rf_waddr, ready); end
    cyc();  // C4: SW in REQ
    ctrl_valid = 1'b0;
    vectors++; if (data_if.data_req_o !== 1'b1 || data_if.data_we_o !== 1'b1 || data_if.data_addr_o !== 32'h44) begin miscompares++; $display("FAIL bb_second got=%b/%b/%h exp=1/1/00000044", data_if.data_req_o, data_if.data_we_o, data_if.data_addr_o); end
    vectors++; if (data_if.data_wdata_o !== 32'hDEAD_BEEF || data_if.data_be_o !== 4'b1111) begin miscompares++; $display("FAIL bb_sw_data got=%h/%b exp=deadbeef/1111", data_if.data_wdata_o, data_if.data_be_o); end
    if (data_if.data_req_o === 1'b1) reqs++;
    data_if.data_gnt_i = 1'b1;
    cyc();
    data_if.data_gnt_i = 1'b0;
    if (data_if.data_req_o === 1'b1) reqs++;
    data_if.data_rvalid_i = 1'b1;
    cyc();
    data_if.data_rvalid_i = 1'b0;
    if (data_if.data_req_o === 1'b1) reqs++;
    vectors++; if (reqs != 2) begin miscompares++; $display("FAIL bb_req_count got=%0d exp=2", reqs); end
    vectors++; if (rf_we !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL bb_end got=%b/%b exp=0/1", rf_we, ready); end
  endtask

  initial begin
    data_if.data_gnt_i    = 1'b0;
    data_if.data_rvalid_i = 1'b0;
    data_if.data_rdata_i  = '0;
    cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_load_byte();
    test_store_half();
    test_store_byte();
    test_misaligned();
    test_illegal();
    test_delayed_gnt();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
